// File: rtl/ms_es_mul_feeder.sv
// Operand sequencer for ms_es_ordered_cas_by2_mul: buffers operand sets in a small FIFO,
// runs one multiplication at a time and presents each result on a valid/ready output.
module ms_es_mul_feeder #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int RES_WIDTH  = DATA_WIDTH * NUM_INPUTS,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data [NUM_INPUTS],
  output logic                  mul_clr,
  output logic                  mul_en,
  output logic [DATA_WIDTH-1:0] mul_data [NUM_INPUTS],
  input  logic                  mul_done,
  input  logic [RES_WIDTH-1:0]  mul_result,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [RES_WIDTH-1:0]  m_data,
  output logic                  m_err,
  output logic                  err_sticky
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CLR  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH][NUM_INPUTS];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [1:0]            state;
  logic [CNT_W-1:0]      run_cnt;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  head_zero;

  assign empty   = (count == '0);
  assign s_ready = (count != (PTR_W + 1)'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  // A set is dispatched from IDLE, or from HOLD on the same edge its predecessor is accepted.
  assign pop     = !empty && ((state == IDLE) || ((state == HOLD) && m_ready));

  // NOTE: give every always_comb output a default first so no path can leave it latched.
  always_comb begin
    head_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (mem[rd_ptr][i] == '0) head_zero = 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy is tracked by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NUM_INPUTS; i++) mem[wr_ptr][i] <= s_data[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mul_clr    <= 1'b0;
      mul_en     <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_err      <= 1'b0;
      err_sticky <= 1'b0;
      run_cnt    <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) mul_data[i] <= '0;
    end else begin
      mul_clr <= 1'b0;
      if (pop) begin
        for (int i = 0; i < NUM_INPUTS; i++) mul_data[i] <= mem[rd_ptr][i];
      end
      case (state)
        IDLE, HOLD: begin
          if ((state == IDLE) || m_ready) begin
            m_valid <= 1'b0;
            if (pop) begin
              if (head_zero) begin
                // Any zero operand makes the product zero; skip the multiplier entirely.
                state   <= HOLD;
                m_valid <= 1'b1;
                m_data  <= '0;
                m_err   <= 1'b0;
              end else begin
                state   <= CLR;
                mul_clr <= 1'b1;
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        CLR: begin
          state   <= RUN;
          mul_en  <= 1'b1;
          run_cnt <= '0;
        end
        RUN: begin
          if (mul_done) begin
            state   <= HOLD;
            mul_en  <= 1'b0;
            m_valid <= 1'b1;
            m_data  <= mul_result;
            m_err   <= 1'b0;
          end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th RUN cycle without done: abort with an error result.
            state      <= HOLD;
            mul_en     <= 1'b0;
            m_valid    <= 1'b1;
            m_data     <= '0;
            m_err      <= 1'b1;
            err_sticky <= 1'b1;
          end else begin
            run_cnt <= run_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
